mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 6 +
 rtl/ld_checksum.sv | 12 +
 rtl/mem_loader.sv | 112 +++++++++++
 tb/tb_mem_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: state encoding and shared constants for the program loader.
package mem_loader_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RUN, ERR} state_t;
    localparam int CSUM_W = 32;
    localparam logic [63:0] STRIDE = 64'd4;
endpackage

// File: rtl/ld_checksum.sv
// ld_checksum: 32-bit wrap-around accumulator with synchronous clear.
module ld_checksum
    import mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [CSUM_W-1:0] data,
    output logic [CSUM_W-1:0] sum
);
    always_ff @(posedge clk) sum <= clr ? '0 : en ? sum + data : sum;
endmodule

// File: rtl/mem_loader.sv
// mem_loader: streams a program into CPU instruction memory, then enables the CPU.
// Define MEM_LOADER_VERIFY_EN to read the image back and compare checksums before RUN.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 9,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            s_valid,
    input  logic [31:0]     s_data,
    input  logic            s_last,
    output logic            s_ready,
    output logic [63:0]     addr_ext,
    output logic            wen_ext,
    output logic            ren_ext,
    output logic [31:0]     wdata_ext,
    input  logic [31:0]     rdata_ext,
    output logic            cpu_enable,
    output logic            done,
    output logic            error,
    output logic [ADDR_W:0] word_count
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
`ifdef MEM_LOADER_VERIFY_EN
    localparam state_t AFTER_LOAD = VERIFY;
`else
    localparam state_t AFTER_LOAD = RUN;
`endif
    state_t state, state_nx;
    logic ended;
    logic hs, ovf, clr;
    logic verify_end, sums_match;
    logic [63:0] waddr, raddr;
    logic [CSUM_W-1:0] load_sum;

    assign hs  = s_valid && s_ready;
    assign ovf = state == LOAD && !ended && s_valid && word_count == DEPTH;
    assign clr = rst || (state == IDLE && start);

    ld_checksum u_load_sum (.clk(clk), .clr(clr), .en(hs), .data(s_data), .sum(load_sum));

`ifdef MEM_LOADER_VERIFY_EN
    logic [ADDR_W+1:0] vcnt;
    logic rd_q;
    logic [CSUM_W-1:0] read_sum;

    ld_checksum u_read_sum (.clk(clk), .clr(clr), .en(rd_q), .data(rdata_ext), .sum(read_sum));

    // vcnt: reads on 0..n-1, last data lands on n, compare on n+1
    always_ff @(posedge clk) begin
        vcnt <= (rst || state != VERIFY) ? '0 : vcnt + 1'b1;
        rd_q <= !rst && ren_ext;
    end
    assign ren_ext    = state == VERIFY && vcnt < {1'b0, word_count};
    assign raddr      = BASE_ADDR + 64'(vcnt) * STRIDE;
    assign verify_end = vcnt == {1'b0, word_count} + 1'b1;
    assign sums_match = read_sum == load_sum;
`else
    logic unused_verify;
    assign ren_ext       = 1'b0;
    assign raddr         = '0;
    assign verify_end    = 1'b0;
    assign sums_match    = 1'b0;
    assign unused_verify = ^{rdata_ext, load_sum};
`endif

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    // ended: s_last accepted; LOAD stays one more cycle so the final write drains before leaving
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = ended ? AFTER_LOAD : ovf ? ERR : LOAD;
            VERIFY:  state_nx = verify_end ? (sums_match ? RUN : ERR) : VERIFY;
            default: state_nx = state;
        endcase
    end

    always_comb begin
        s_ready    = state == LOAD && !ended && word_count < DEPTH;
        addr_ext   = ren_ext ? raddr : waddr;
        cpu_enable = state == RUN;
        done       = state == RUN;
        error      = state == ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
            ended      <= 1'b0;
            wen_ext    <= 1'b0;
            waddr      <= '0;
            wdata_ext  <= '0;
        end else begin
            wen_ext <= hs;
            if (state == IDLE && start) begin
                word_count <= '0;
                ended      <= 1'b0;
            end
            if (hs) begin
                word_count <= word_count + 1'b1;
                ended      <= s_last;
                waddr      <= BASE_ADDR + 64'(word_count) * STRIDE;
                wdata_ext  <= s_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: table-driven and randomized checks of mem_loader against a queue-based reference.
module tb_mem_loader;
`ifdef MEM_LOADER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam logic [63:0] B2 = 64'h1000;

    typedef struct {
        int n;
        int gap_at;
        int gap_len;
        bit fixed;
        bit corrupt;
        int exp_wc;
        bit exp_err_v;
    } row_t;

    logic clk = 1'b0;
    logic rst, start, s_valid, s_last, s_ready, wen_ext, ren_ext, cpu_enable, done, error;
    logic [31:0] s_data, wdata_ext, rdata_ext;
    logic [63:0] addr_ext;
    logic [9:0] word_count;

    logic b_start, b_valid, b_last, b_ready, b_wen, b_ren, b_cpu, b_done, b_err;
    logic [31:0] b_data, b_wdata, b_rdata;
    logic [63:0] b_addr;
    logic [2:0] b_wc;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit corrupt = 1'b0;
    logic [31:0] mem [0:1023];
    logic [31:0] fixw [0:2];
    row_t rows [7];

    int hs_cyc[$];
    int w_cyc[$];
    logic [63:0] w_addr[$];
    logic [31:0] w_data[$];
    logic [63:0] r_addr[$];
    int viol = 0;
    int first_end = -1;

    mem_loader #(.ADDR_W(9), .BASE_ADDR(64'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext), .cpu_enable(cpu_enable), .done(done),
        .error(error), .word_count(word_count)
    );

    mem_loader #(.ADDR_W(2), .BASE_ADDR(B2)) dut2 (
        .clk(clk), .rst(rst), .start(b_start), .s_valid(b_valid), .s_data(b_data), .s_last(b_last),
        .s_ready(b_ready), .addr_ext(b_addr), .wen_ext(b_wen), .ren_ext(b_ren),
        .wdata_ext(b_wdata), .rdata_ext(b_rdata), .cpu_enable(b_cpu), .done(b_done),
        .error(b_err), .word_count(b_wc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instruction memory model; optional corruption of the word at byte 0x4 on readback
    always @(posedge clk) begin
        if (wen_ext) mem[addr_ext[11:2]] <= wdata_ext;
        if (ren_ext) rdata_ext <= (corrupt && addr_ext == 64'h4) ? 32'h0 : mem[addr_ext[11:2]];
    end

    always @(negedge clk) begin
        if (s_valid && s_ready) hs_cyc.push_back(cyc);
        if (wen_ext) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(addr_ext);
            w_data.push_back(wdata_ext);
        end
        if (ren_ext) r_addr.push_back(addr_ext);
        if ((wen_ext && ren_ext) || (cpu_enable && (wen_ext || ren_ext))) viol++;
        if ((done || error) && first_end < 0) first_end = cyc;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        hs_cyc.delete();
        w_cyc.delete();
        w_addr.delete();
        w_data.delete();
        r_addr.delete();
        viol = 0;
        first_end = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        b_start = 1'b0;
        b_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " flags"}, {wen_ext, ren_ext, s_ready, cpu_enable, done, error}, 0);
        chk({tag, " addr"}, addr_ext, 0);
        chk({tag, " wdata"}, wdata_ext, 0);
        chk({tag, " word_count"}, word_count, 0);
    endtask

    task automatic send(input logic [31:0] d, input logic l, inout int stalls);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        @(negedge clk);
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        stalls += t;
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic run_row(input row_t r, input bit with_rst);
        logic [31:0] w[$];
        logic [31:0] v;
        int stalls, t, last_hs;
        bit exp_err;
        stalls = 0;
        exp_err = VER && r.exp_err_v;
        if (with_rst) do_reset();
        clear_mon();
        corrupt = r.corrupt;
        for (int i = 0; i < r.n; i++) begin
            v = r.fixed ? fixw[i] : $urandom();
            if (r.corrupt && i == 1) v = v | 32'h1;
            w.push_back(v);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < r.n; i++) begin
            send(w[i], i == r.n - 1, stalls);
            if (i == r.gap_at) repeat (r.gap_len) tick();
        end
        t = 0;
        while (first_end < 0 && t < r.n + 20) begin
            tick();
            t++;
        end
        repeat (3) tick();
        @(negedge clk);
        last_hs = hs_cyc.size() > 0 ? hs_cyc[hs_cyc.size()-1] : -100;
        chk($sformatf("n=%0d stalls", r.n), stalls, 0);
        chk($sformatf("n=%0d handshakes", r.n), hs_cyc.size(), r.n);
        chk($sformatf("n=%0d writes", r.n), w_cyc.size(), r.n);
        for (int i = 0; i < w_cyc.size() && i < hs_cyc.size() && i < r.n; i++) begin
            chk($sformatf("n=%0d wen cycle %0d", r.n, i), w_cyc[i], hs_cyc[i] + 1);
            chk($sformatf("n=%0d waddr %0d", r.n, i), w_addr[i], 4 * i);
            chk($sformatf("n=%0d wdata %0d", r.n, i), w_data[i], w[i]);
        end
        chk($sformatf("n=%0d reads", r.n), r_addr.size(), VER ? r.n : 0);
        for (int i = 0; i < r_addr.size(); i++)
            chk($sformatf("n=%0d raddr %0d", r.n, i), r_addr[i], 4 * i);
        chk($sformatf("n=%0d end cycle", r.n), first_end, last_hs + 2 + (VER ? r.n + 2 : 0));
        chk($sformatf("n=%0d error", r.n), error, exp_err);
        chk($sformatf("n=%0d cpu_enable", r.n), cpu_enable, !exp_err);
        chk($sformatf("n=%0d done", r.n), done, !exp_err);
        chk($sformatf("n=%0d word_count", r.n), word_count, r.exp_wc);
        chk($sformatf("n=%0d port overlap", r.n), viol, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        chk($sformatf("n=%0d start ignored", r.n), {done, error, s_ready}, {!exp_err, exp_err, 1'b0});
        chk($sformatf("n=%0d start ignored wc", r.n), word_count, r.exp_wc);
    endtask

    task automatic abort_test();
        int st;
        st = 0;
        do_reset();
        clear_mon();
        corrupt = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
        for (int i = 0; i < 3; i++) send(fixw[i], i == 2, st);
        tick();
        tick();
`else
        send(fixw[0], 1'b0, st);
        send(fixw[1], 1'b0, st);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("abort");
        chk("abort reads before rst", r_addr.size(), VER ? 2 : 0);
        clear_mon();
        repeat (3) tick();
        @(negedge clk);
        chk("abort quiet", w_cyc.size() + r_addr.size(), 0);
        chk("abort s_ready", s_ready, 0);
    endtask

    task automatic overflow_test();
        logic [31:0] d [5];
        int k, err_at, wn, rn;
        k = 0;
        err_at = -1;
        wn = 0;
        rn = 0;
        for (int i = 0; i < 5; i++) d[i] = $urandom();
        do_reset();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1;
        b_last = 1'b0;
        for (int j = 0; j < 8; j++) begin
            b_data = d[k < 5 ? k : 4];
            @(negedge clk);
            if (b_wen) begin
                chk($sformatf("ovf waddr %0d", wn), b_addr, B2 + 64'(4 * wn));
                chk($sformatf("ovf wdata %0d", wn), b_wdata, d[wn < 5 ? wn : 4]);
                wn++;
            end
            if (b_ren) rn++;
            if (b_err && err_at < 0) err_at = j;
            if (b_valid && b_ready) k++;
            tick();
        end
        b_valid = 1'b0;
        chk("ovf accepted", k, 4);
        chk("ovf writes", wn, 4);
        chk("ovf reads", rn, 0);
        chk("ovf error cycle", err_at, 5);
        @(negedge clk);
        chk("ovf status", {b_err, b_cpu, b_done, b_ready}, 4'b1000);
        chk("ovf word_count", b_wc, 4);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        b_start = 1'b0;
        b_valid = 1'b0;
        b_data = '0;
        b_last = 1'b0;
        b_rdata = '0;
        fixw[0] = 32'h00500093;
        fixw[1] = 32'h00a00113;
        fixw[2] = 32'h002081b3;
        rows[0] = '{3, -1, 0, 1'b1, 1'b0, 3, 1'b0};
        rows[1] = '{3, -1, 0, 1'b1, 1'b1, 3, 1'b1};
        rows[2] = '{8, 3, 2, 1'b0, 1'b0, 8, 1'b0};
        rows[3] = '{1, -1, 0, 1'b0, 1'b0, 1, 1'b0};
        rows[4] = '{20, int'($urandom_range(0, 18)), int'($urandom_range(1, 3)), 1'b0, 1'b0, 20, 1'b0};
        rows[5] = '{512, 100, 1, 1'b0, 1'b0, 512, 1'b0};
        rows[6] = '{6, -1, 0, 1'b0, 1'b1, 6, 1'b1};
        do_reset();
        @(negedge clk);
        check_zero("reset");
        for (int i = 0; i < 7; i++) run_row(rows[i], 1'b1);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_zero("rst over start");
        tick();
        @(negedge clk);
        chk("rst over start s_ready", s_ready, 0);
        abort_test();
        run_row(rows[0], 1'b0);
        overflow_test();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
